// File: rtl/id_stage_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package : id_pkg
// Purpose : Shared constants for the MIPS ID stage: opcode encodings and the
//           bit positions of the instruction fields.
// Rev     : 1.0  initial release
// ============================================================================
package id_pkg;

  // Opcode encodings (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // Instruction field bit positions
  localparam int F_OPC_MSB   = 31;
  localparam int F_OPC_LSB   = 26;
  localparam int F_RS_MSB    = 25;
  localparam int F_RS_LSB    = 21;
  localparam int F_RT_MSB    = 20;
  localparam int F_RT_LSB    = 16;
  localparam int F_RD_MSB    = 15;
  localparam int F_RD_LSB    = 11;
  localparam int F_FUNCT_MSB = 5;
  localparam int F_FUNCT_LSB = 0;
  localparam int F_IMM_MSB   = 15;
  localparam int F_IMM_LSB   = 0;
  localparam int F_JIDX_MSB  = 25;
  localparam int F_JIDX_LSB  = 0;

endpackage : id_pkg
`default_nettype wire

// File: rtl/id_stage_pipe_if.sv
`default_nettype none
// ============================================================================
// Interface : id_stage_pipe_if
// Purpose   : Bundles the IF/ID inputs, the WB write-back port and the ID/EX
//             outputs of the decode stage.
//   slave  modport : used by id_stage_pipe (consumes IF/WB, drives ex_*/stall)
//   master modport : used by the surrounding pipeline / testbench
// Params    : DATA_W datapath width
// Rev       : 1.0  initial release
// ============================================================================
interface id_stage_pipe_if #(
  parameter int DATA_W = 32
);
  // IF/ID side
  logic [31:0]       instr_in;
  logic [DATA_W-1:0] pc4_in;
  logic              if_valid;
  logic              flush;
  // WB write-back
  logic              wb_we;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  // Hazard
  logic              stall;
  // ID/EX register
  logic              ex_valid;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [DATA_W-1:0] ex_jtarget;
  logic [DATA_W-1:0] ex_pc4;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_dst;
  logic [5:0]        ex_funct;
  logic [5:0]        ex_opcode;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;

  modport slave (
    input  instr_in, pc4_in, if_valid, flush, wb_we, wb_addr, wb_data,
    output stall, ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_jtarget, ex_pc4,
           ex_rs, ex_rt, ex_dst, ex_funct, ex_opcode,
           ex_reg_write, ex_mem_read, ex_mem_write
  );

  modport master (
    output instr_in, pc4_in, if_valid, flush, wb_we, wb_addr, wb_data,
    input  stall, ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_jtarget, ex_pc4,
           ex_rs, ex_rt, ex_dst, ex_funct, ex_opcode,
           ex_reg_write, ex_mem_read, ex_mem_write
  );

endinterface : id_stage_pipe_if
`default_nettype wire

// File: rtl/id_stage_pipe_rf.sv
`default_nettype none
// ============================================================================
// Module  : reg_file_2r1w
// Purpose : Register file with 2 asynchronous read ports and 1 synchronous
//           write port. r0 and indices >= NUM_REGS always read 0.
// Ports   : clk, rst_n (async active-low, clears every register)
//           i_raddr1/o_rdata1, i_raddr2/o_rdata2 : read ports
//           i_we, i_waddr, i_wdata               : write port
// Config  : ID_FWD_EN - when defined, a read of the register being written
//           this cycle returns i_wdata (write-through bypass).
// Params  : DATA_W width, NUM_REGS register count (<= 32)
// Rev     : 1.0  initial release
// ============================================================================
module reg_file_2r1w #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic [4:0]        i_raddr1,
  input  wire logic [4:0]        i_raddr2,
  output logic      [DATA_W-1:0] o_rdata1,
  output logic      [DATA_W-1:0] o_rdata2,
  input  wire logic              i_we,
  input  wire logic [4:0]        i_waddr,
  input  wire logic [DATA_W-1:0] i_wdata
);

  // All 32 address slots exist as wires; only 1..NUM_REGS-1 are storage,
  // the rest are tied to zero so out-of-range reads naturally return 0.
  logic [DATA_W-1:0] w_regs [32];

  for (genvar gi = 0; gi < 32; gi++) begin : g_regs
    if (gi != 0 && gi < NUM_REGS) begin : g_live
      logic [DATA_W-1:0] r_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          r_q <= '0;
        else if (i_we && (i_waddr == 5'(gi)))
          r_q <= i_wdata;
      end
      assign w_regs[gi] = r_q;
    end else begin : g_zero
      assign w_regs[gi] = '0;
    end
  end

  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  assign w_rd1 = w_regs[i_raddr1];
  assign w_rd2 = w_regs[i_raddr2];

`ifdef ID_FWD_EN
  // Only writes that actually land in storage are bypassed.
  logic w_wr_live;
  assign w_wr_live = i_we && (i_waddr != 5'd0) && (32'(i_waddr) < 32'(NUM_REGS));
  assign o_rdata1  = (w_wr_live && (i_waddr == i_raddr1)) ? i_wdata : w_rd1;
  assign o_rdata2  = (w_wr_live && (i_waddr == i_raddr2)) ? i_wdata : w_rd2;
`else
  assign o_rdata1 = w_rd1;
  assign o_rdata2 = w_rd2;
`endif

endmodule : reg_file_2r1w
`default_nettype wire

// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module  : id_stage_pipe
// Purpose : MIPS decode stage. Splits the instruction, reads the register
//           file, extends the immediate, decodes EX/MEM/WB controls and
//           registers everything into the ID/EX register (1-cycle latency).
//           Detects load-use hazards (stall + bubble) and honours flush.
// Ports   : clock, reset_n (async active-low)
//           bus (id_stage_pipe_if.slave): IF/ID inputs, WB write port,
//           combinational stall and the registered ex_* outputs.
// Config  : ID_FWD_EN - enables register-file write-through bypass.
// Params  : DATA_W (>= 32), NUM_REGS (<= 32)
// Rev     : 1.0  initial release
// ============================================================================
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  wire logic      clock,
  input  wire logic      reset_n,
  id_stage_pipe_if.slave bus
);

  // ---------------- field split ----------------
  logic [5:0]  w_opcode;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [5:0]  w_funct;
  logic [15:0] w_imm16;
  logic [25:0] w_jidx;

  assign w_opcode = bus.instr_in[F_OPC_MSB:F_OPC_LSB];
  assign w_rs     = bus.instr_in[F_RS_MSB:F_RS_LSB];
  assign w_rt     = bus.instr_in[F_RT_MSB:F_RT_LSB];
  assign w_rd     = bus.instr_in[F_RD_MSB:F_RD_LSB];
  assign w_funct  = bus.instr_in[F_FUNCT_MSB:F_FUNCT_LSB];
  assign w_imm16  = bus.instr_in[F_IMM_MSB:F_IMM_LSB];
  assign w_jidx   = bus.instr_in[F_JIDX_MSB:F_JIDX_LSB];

  // ---------------- register file ----------------
  logic [DATA_W-1:0] w_rs_data;
  logic [DATA_W-1:0] w_rt_data;

  reg_file_2r1w #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_rf (
    .clk      (clock),
    .rst_n    (reset_n),
    .i_raddr1 (w_rs),
    .i_raddr2 (w_rt),
    .o_rdata1 (w_rs_data),
    .o_rdata2 (w_rt_data),
    .i_we     (bus.wb_we),
    .i_waddr  (bus.wb_addr),
    .i_wdata  (bus.wb_data)
  );

  // ---------------- control decode ----------------
  logic w_is_rtype, w_is_lw, w_is_sw, w_is_beq, w_is_bne;
  logic w_is_addi, w_is_slti, w_is_andi, w_is_ori, w_is_xori;
  logic w_reg_write, w_mem_read, w_mem_write, w_uses_rt, w_zext;
  logic [4:0] w_dst;

  always_comb begin
    w_is_rtype  = (w_opcode == OP_RTYPE);
    w_is_lw     = (w_opcode == OP_LW);
    w_is_sw     = (w_opcode == OP_SW);
    w_is_beq    = (w_opcode == OP_BEQ);
    w_is_bne    = (w_opcode == OP_BNE);
    w_is_addi   = (w_opcode == OP_ADDI);
    w_is_slti   = (w_opcode == OP_SLTI);
    w_is_andi   = (w_opcode == OP_ANDI);
    w_is_ori    = (w_opcode == OP_ORI);
    w_is_xori   = (w_opcode == OP_XORI);
    w_reg_write = w_is_rtype | w_is_lw | w_is_addi | w_is_slti |
                  w_is_andi  | w_is_ori | w_is_xori;
    w_mem_read  = w_is_lw;
    w_mem_write = w_is_sw;
    // Instructions that actually consume the rt register value
    w_uses_rt   = w_is_rtype | w_is_beq | w_is_bne | w_is_sw;
    // Logical immediates are unsigned; everything else sign-extends
    w_zext      = w_is_andi | w_is_ori | w_is_xori;
    w_dst       = w_is_rtype ? w_rd : w_rt;
  end

  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_jtarget;

  assign w_imm     = w_zext ? {{(DATA_W-16){1'b0}}, w_imm16}
                            : {{(DATA_W-16){w_imm16[15]}}, w_imm16};
  assign w_jtarget = {bus.pc4_in[DATA_W-1:28], w_jidx, 2'b00};

  // ---------------- ID/EX register state ----------------
  logic              r_ex_valid;
  logic [DATA_W-1:0] r_ex_rs_data;
  logic [DATA_W-1:0] r_ex_rt_data;
  logic [DATA_W-1:0] r_ex_imm;
  logic [DATA_W-1:0] r_ex_jtarget;
  logic [DATA_W-1:0] r_ex_pc4;
  logic [4:0]        r_ex_rs;
  logic [4:0]        r_ex_rt;
  logic [4:0]        r_ex_dst;
  logic [5:0]        r_ex_funct;
  logic [5:0]        r_ex_opcode;
  logic              r_ex_reg_write;
  logic              r_ex_mem_read;
  logic              r_ex_mem_write;

  // ---------------- load-use hazard ----------------
  // A load in EX whose destination feeds this instruction forces one bubble.
  // Flush wins: the instruction is being squashed anyway, so no stall.
  logic w_stall;
  logic w_issue;

  assign w_stall = bus.if_valid & r_ex_valid & r_ex_mem_read & (r_ex_dst != 5'd0) &
                   ((r_ex_dst == w_rs) | (w_uses_rt & (r_ex_dst == w_rt))) &
                   ~bus.flush;
  assign w_issue = bus.if_valid & ~w_stall & ~bus.flush;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ex_valid     <= 1'b0;
      r_ex_rs_data   <= '0;
      r_ex_rt_data   <= '0;
      r_ex_imm       <= '0;
      r_ex_jtarget   <= '0;
      r_ex_pc4       <= '0;
      r_ex_rs        <= '0;
      r_ex_rt        <= '0;
      r_ex_dst       <= '0;
      r_ex_funct     <= '0;
      r_ex_opcode    <= '0;
      r_ex_reg_write <= 1'b0;
      r_ex_mem_read  <= 1'b0;
      r_ex_mem_write <= 1'b0;
    end else if (w_issue) begin
      r_ex_valid     <= 1'b1;
      r_ex_rs_data   <= w_rs_data;
      r_ex_rt_data   <= w_rt_data;
      r_ex_imm       <= w_imm;
      r_ex_jtarget   <= w_jtarget;
      r_ex_pc4       <= bus.pc4_in;
      r_ex_rs        <= w_rs;
      r_ex_rt        <= w_rt;
      r_ex_dst       <= w_dst;
      r_ex_funct     <= w_funct;
      r_ex_opcode    <= w_opcode;
      r_ex_reg_write <= w_reg_write;
      r_ex_mem_read  <= w_mem_read;
      r_ex_mem_write <= w_mem_write;
    end else begin
      // Bubble: kill valid and controls, data fields simply hold
      r_ex_valid     <= 1'b0;
      r_ex_reg_write <= 1'b0;
      r_ex_mem_read  <= 1'b0;
      r_ex_mem_write <= 1'b0;
    end
  end

  // ---------------- outputs ----------------
  assign bus.stall        = w_stall;
  assign bus.ex_valid     = r_ex_valid;
  assign bus.ex_rs_data   = r_ex_rs_data;
  assign bus.ex_rt_data   = r_ex_rt_data;
  assign bus.ex_imm       = r_ex_imm;
  assign bus.ex_jtarget   = r_ex_jtarget;
  assign bus.ex_pc4       = r_ex_pc4;
  assign bus.ex_rs        = r_ex_rs;
  assign bus.ex_rt        = r_ex_rt;
  assign bus.ex_dst       = r_ex_dst;
  assign bus.ex_funct     = r_ex_funct;
  assign bus.ex_opcode    = r_ex_opcode;
  assign bus.ex_reg_write = r_ex_reg_write;
  assign bus.ex_mem_read  = r_ex_mem_read;
  assign bus.ex_mem_write = r_ex_mem_write;

endmodule : id_stage_pipe
`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_id_stage_pipe
// Purpose : Self-checking bench for id_stage_pipe. The driver pushes the
//           expected ID/EX contents of every issued instruction into a queue;
//           a monitor pops and compares whenever ex_valid is seen.
//           Stall/bubble/reset behaviour is checked directly by the driver.
// Rev     : 1.0  initial release
// ============================================================================
module tb_id_stage_pipe;

  logic clk;
  logic rst_n;

  id_stage_pipe_if #(.DATA_W(32)) bus ();

  id_stage_pipe #(
    .DATA_W   (32),
    .NUM_REGS (32)
  ) u_dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs_d;
    logic [31:0] rt_d;
    logic [31:0] imm;
    logic [31:0] jt;
    logic [31:0] pc4;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [5:0]  funct;
    logic [5:0]  op;
    logic        rw;
    logic        mr;
    logic        mw;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.wb_we    = 1'b0;
    bus.wb_addr  = 5'd0;
    bus.wb_data  = 32'd0;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    bus.if_valid = 1'b0;
    bus.wb_we    = 1'b1;
    bus.wb_addr  = a;
    bus.wb_data  = d;
    tick();
    bus.wb_we    = 1'b0;
  endtask

  // Presents an instruction, records its expected ID/EX image, clocks it in.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc4,
                       input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic [31:0] imm, input logic [4:0] dst,
                       input logic rw, input logic mr, input logic mw);
    exp_t e;
    bus.instr_in = instr;
    bus.pc4_in   = pc4;
    bus.if_valid = 1'b1;
    bus.flush    = 1'b0;
    e.rs_d  = rsd;
    e.rt_d  = rtd;
    e.imm   = imm;
    e.jt    = {pc4[31:28], instr[25:0], 2'b00};
    e.pc4   = pc4;
    e.rs    = instr[25:21];
    e.rt    = instr[20:16];
    e.dst   = dst;
    e.funct = instr[5:0];
    e.op    = instr[31:26];
    e.rw    = rw;
    e.mr    = mr;
    e.mw    = mw;
    q.push_back(e);
    tick();
    bus.if_valid = 1'b0;
    bus.wb_we    = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && bus.ex_valid) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_issue: got opcode %h dst %0d expected no instruction",
                 bus.ex_opcode, bus.ex_dst);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ex_rs_data", bus.ex_rs_data, e.rs_d);
        chk("ex_rt_data", bus.ex_rt_data, e.rt_d);
        chk("ex_imm",     bus.ex_imm,     e.imm);
        chk("ex_jtarget", bus.ex_jtarget, e.jt);
        chk("ex_pc4",     bus.ex_pc4,     e.pc4);
        chk("ex_rs",      32'(bus.ex_rs),     32'(e.rs));
        chk("ex_rt",      32'(bus.ex_rt),     32'(e.rt));
        chk("ex_dst",     32'(bus.ex_dst),    32'(e.dst));
        chk("ex_funct",   32'(bus.ex_funct),  32'(e.funct));
        chk("ex_opcode",  32'(bus.ex_opcode), 32'(e.op));
        chk("ex_ctrl",    {29'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write},
                          {29'd0, e.rw, e.mr, e.mw});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] PC = 32'h0000_0100;
  logic [31:0] fwd_val;

  initial begin
`ifdef ID_FWD_EN
    fwd_val = 32'h1234_5678;
`else
    fwd_val = 32'h0;
`endif
    bus.instr_in = 32'd0;
    bus.pc4_in   = 32'd0;
    idle_inputs();
    rst_n = 1'b0;

    // ---- reset state ----
    #3;
    chk("rst_ex_valid",   32'(bus.ex_valid), 32'd0);
    chk("rst_stall",      32'(bus.stall), 32'd0);
    chk("rst_ex_rs_data", bus.ex_rs_data, 32'd0);
    chk("rst_ex_imm",     bus.ex_imm, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---- register write then read ----
    wb_write(5'd5, 32'hDEAD_BEEF);
    wb_write(5'd1, 32'h0000_0040);
    wb_write(5'd2, 32'h0000_0007);
    issue(rtype(5, 0, 6, 32), PC, 32'hDEAD_BEEF, 32'd0, 32'h0000_3020, 5'd6, 1'b1, 1'b0, 1'b0);

    // Same-cycle write and dependent read
    bus.wb_we = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h1234_5678;
    issue(rtype(9, 0, 10, 32), PC, fwd_val, 32'd0, 32'h0000_5020, 5'd10, 1'b1, 1'b0, 1'b0);
    issue(rtype(9, 9, 11, 32), PC, 32'h1234_5678, 32'h1234_5678, 32'h0000_5820, 5'd11, 1'b1, 1'b0, 1'b0);

    // ---- load-use hazard: lw r3,0(r1) ; add r4,r3,r2 ----
    issue(itype(35, 1, 3, 16'h0), PC, 32'h40, 32'd0, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0);
    bus.instr_in = rtype(3, 2, 4, 32); bus.pc4_in = PC; bus.if_valid = 1'b1;
    #1;
    chk("hazard_stall", 32'(bus.stall), 32'd1);
    tick();
    chk("bubble_ex_valid",     32'(bus.ex_valid), 32'd0);
    chk("bubble_ex_reg_write", 32'(bus.ex_reg_write), 32'd0);
    chk("stall_one_cycle",     32'(bus.stall), 32'd0);
    issue(rtype(3, 2, 4, 32), PC, 32'd0, 32'd7, 32'h0000_2020, 5'd4, 1'b1, 1'b0, 1'b0);

    // ---- no hazard: lw r3 ; addi r7,r8,1 (rt not read) ----
    issue(itype(35, 1, 3, 16'h0), PC, 32'h40, 32'd0, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0);
    bus.instr_in = itype(8, 8, 7, 16'h1); bus.if_valid = 1'b1;
    #1;
    chk("addi_no_stall", 32'(bus.stall), 32'd0);
    issue(itype(8, 8, 7, 16'h1), PC, 32'd0, 32'd0, 32'd1, 5'd7, 1'b1, 1'b0, 1'b0);

    // lw r0 ; add r12,r0,r0 -> no stall
    issue(itype(35, 1, 0, 16'h0), PC, 32'h40, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    bus.instr_in = rtype(0, 0, 12, 32); bus.if_valid = 1'b1;
    #1;
    chk("lw_r0_no_stall", 32'(bus.stall), 32'd0);
    issue(rtype(0, 0, 12, 32), PC, 32'd0, 32'd0, 32'h0000_6020, 5'd12, 1'b1, 1'b0, 1'b0);

    // ---- hazard with flush in the same cycle ----
    issue(itype(35, 1, 3, 16'h0), PC, 32'h40, 32'd0, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0);
    bus.instr_in = rtype(3, 2, 4, 32); bus.if_valid = 1'b1; bus.flush = 1'b1;
    #1;
    chk("flush_beats_stall", 32'(bus.stall), 32'd0);
    tick();
    chk("flush_bubble", 32'(bus.ex_valid), 32'd0);
    idle_inputs();

    // ---- write to r0 is ignored ----
    bus.wb_we = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hFFFF_FFFF;
    issue(rtype(0, 0, 13, 32), PC, 32'd0, 32'd0, 32'h0000_6820, 5'd13, 1'b1, 1'b0, 1'b0);
    issue(rtype(0, 0, 14, 32), PC, 32'd0, 32'd0, 32'h0000_7020, 5'd14, 1'b1, 1'b0, 1'b0);

    // sw r2,4(r1)
    issue(itype(43, 1, 2, 16'h4), PC, 32'h40, 32'd7, 32'd4, 5'd2, 1'b0, 1'b0, 1'b1);

    // ---- immediate extension and jump target ----
    issue(itype(12, 0, 20, 16'h8000), PC, 32'd0, 32'd0, 32'h0000_8000, 5'd20, 1'b1, 1'b0, 1'b0);
    issue(itype(8, 0, 21, 16'h8000), PC, 32'd0, 32'd0, 32'hFFFF_8000, 5'd21, 1'b1, 1'b0, 1'b0);
    issue({6'd2, 26'h000_0010}, 32'hA000_0004, 32'd0, 32'd0, 32'h0000_0010, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("j_target", bus.ex_jtarget, 32'hA000_0040);

    // ---- reset mid-stream ----
    issue(itype(35, 1, 3, 16'h0), PC, 32'h40, 32'd0, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    bus.instr_in = rtype(3, 2, 4, 32); bus.if_valid = 1'b1;
    #1;
    chk("pre_reset_stall", 32'(bus.stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("async_rst_mem_read", 32'(bus.ex_mem_read), 32'd0);
    chk("async_rst_rs_data",  bus.ex_rs_data, 32'd0);
    chk("async_rst_stall",    32'(bus.stall), 32'd0);
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    issue(rtype(5, 0, 15, 32), PC, 32'd0, 32'd0, 32'h0000_7820, 5'd15, 1'b1, 1'b0, 1'b0);

    tick();
    tick();
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_id_stage_pipe
`default_nettype wire
